// File: rtl/operaciones_pkg.sv
// Shared constants for the 12-bit arithmetic result path.
// Holds opcode encodings and the default operand width.
// No logic; imported by the interface, ALU, FIFO glue and top.
package operaciones_pkg;

  localparam int DEF_W = 12;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/operaciones_if.sv
// Operand and result handshake bundle for operaciones_resp.
// master = operand producer / result consumer; slave = the block.
// Both directions use valid/ready; op_count travels with the result side.
interface operaciones_if
  import operaciones_pkg::*;
#(
  parameter int W = DEF_W
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  C;
  logic          flag;
  logic          zero;
  logic [15:0]   op_count;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, C, flag, zero, op_count
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, C, flag, zero, op_count
  );
endinterface

// File: rtl/operaciones_alu.sv
// Combinational 12-bit ALU: add, sub, and, xor with carry/borrow flag.
// Latency: zero cycles (pure combinational).
// No backpressure; evaluated every cycle, used only on accept.
module operaciones_alu
  import operaciones_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [W-1:0] c_o,
  output logic         flag_o,
  output logic         zero_o
);

  logic [W:0] res;

  // One extra bit carries the add carry-out or the subtract borrow.
  always_comb begin
    res = '0;
    case (op_i)
      OP_ADD:  res = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  res = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  res = {1'b0, a_i & b_i};
      default: res = {1'b0, a_i ^ b_i};
    endcase
  end

  assign c_o    = res[W-1:0];
  assign flag_o = res[W];
  assign zero_o = (res[W-1:0] == '0);

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy counter and registered head.
// Latency: a push is visible at the head one cycle later.
// Push is ignored when full (even with a same-cycle pop); pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  // full/empty come from the registered count only, never from pop_i.
  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/operaciones_resp.sv
// Operand consumer: computes A op B on accept and queues {C,flag,zero}.
// Latency: one cycle from accept to out_valid on an empty queue.
// in_ready = !full from registered state; a full queue refuses push even on pop.
module operaciones_resp
  import operaciones_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  operaciones_if.slave  bus
);

  logic [W-1:0]  alu_c;
  logic          alu_flag, alu_zero;
  logic [W+1:0]  head_dat;
  logic          full, empty, accept, pop;
  logic [15:0]   op_count_q, op_count_d;

  operaciones_alu #(.W(W)) u_alu (
    .a_i    (bus.A),
    .b_i    (bus.B),
    .op_i   (bus.op),
    .c_o    (alu_c),
    .flag_o (alu_flag),
    .zero_o (alu_zero)
  );

  sync_fifo #(.WIDTH(W + 2), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (accept),
    .push_dat_i ({alu_c, alu_flag, alu_zero}),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .head_dat_o (head_dat)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign accept        = bus.in_valid && !full;
  assign pop           = !empty && bus.out_ready;
  assign bus.C         = head_dat[W+1:2];
  assign bus.flag      = head_dat[1];
  assign bus.zero      = head_dat[0];
  assign bus.op_count  = op_count_q;

  // Accepted-operand counter next-state; wraps at 16 bits.
  always_comb begin
    op_count_d = op_count_q;
    if (accept) op_count_d = op_count_q + 16'd1;
  end

  // Accepted-operand counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

endmodule

// File: tb/tb_operaciones_resp.sv
// Bench for operaciones_resp: queue-based reference model plus directed vectors.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Every comparison steps checks; mismatches step failures and print a FAIL line.
module tb_operaciones_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  operaciones_if #(.W(12)) bus ();

  operaciones_resp #(.W(12), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] c;
    logic        f;
    logic        z;
  } res_t;

  res_t        mq[$];
  int unsigned mcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected result straight from the arithmetic rules on plain integers.
  function automatic res_t calc(input int a, input int b, input int op);
    res_t x;
    int   r;
    case (op)
      0: begin r = a + b;  x.f = (r > 4095); end
      1: begin r = (a - b + 4096) % 4096; x.f = (a < b); end
      2: begin r = a & b;  x.f = 1'b0; end
      default: begin r = a ^ b; x.f = 1'b0; end
    endcase
    x.c = 12'(r % 4096);
    x.z = (x.c == 12'h000);
    return x;
  endfunction

  // Reference model: transactions move at each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit acc, pp;
      acc = bus.in_valid && (mq.size() < 4);
      pp  = (mq.size() > 0) && bus.out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(calc(int'(bus.A), int'(bus.B), int'(bus.op)));
        mcnt = (mcnt + 1) % 65536;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("cyc_in_ready", 32'(bus.in_ready), 32'(mq.size() < 4));
      chk("cyc_op_count", 32'(bus.op_count), mcnt);
      if (mq.size() != 0) begin
        chk("cyc_C", 32'(bus.C), 32'(mq[0].c));
        chk("cyc_flag", 32'(bus.flag), 32'(mq[0].f));
        chk("cyc_zero", 32'(bus.zero), 32'(mq[0].z));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transaction while stalled, check the head literally, then pop it.
  task automatic one(input logic [11:0] a, input logic [11:0] b, input logic [1:0] op,
                     input logic [11:0] ec, input logic ef, input logic ez, input string nm);
    bus.out_ready = 1'b0;
    bus.A = a; bus.B = b; bus.op = op; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_C"}, 32'(bus.C), 32'(ec));
    chk({nm, "_flag"}, 32'(bus.flag), 32'(ef));
    chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.op = 2'b00; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_C", 32'(bus.C), 32'd0);
    chk("rst_flag", 32'(bus.flag), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    rst = 1'b0;

    // Single add, then wrap/borrow/zero corner cases.
    one(12'h7FF, 12'h001, 2'b00, 12'h800, 1'b0, 1'b0, "add1");
    chk("add1_op_count", 32'(bus.op_count), 32'd1);
    one(12'hFFF, 12'h001, 2'b00, 12'h000, 1'b1, 1'b1, "add_wrap");
    one(12'h000, 12'h001, 2'b01, 12'hFFF, 1'b1, 1'b0, "sub_borrow");
    one(12'hAAA, 12'hAAA, 2'b11, 12'h000, 1'b0, 1'b1, "xor_self");
    one(12'h0F0, 12'h3CC, 2'b10, 12'h0C0, 1'b0, 1'b0, "and_mix");

    // Backpressure: five attempts, four accepted, head held steady.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.B = 12'h010; bus.op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      bus.A = 12'h100 + 12'(i);
      step();
      chk("stall_head_C", 32'(bus.C), 32'h110);
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_op_count", 32'(bus.op_count), 32'd9);
    step();
    chk("stall_hold_C", 32'(bus.C), 32'h110);

    // Full with push and pop together: pop wins, push lands next edge.
    bus.in_valid = 1'b1; bus.A = 12'h200; bus.B = 12'h001; bus.op = 2'b00; bus.out_ready = 1'b1;
    step();
    chk("fullpp_op_count", 32'(bus.op_count), 32'd9);
    chk("fullpp_head", 32'(bus.C), 32'h111);
    chk("fullpp_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("retry_op_count", 32'(bus.op_count), 32'd10);
    chk("retry_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("drained", 32'(bus.out_valid), 32'd0);

    // Streaming AND: one in, one out every cycle.
    bus.in_valid = 1'b1; bus.B = 12'h555; bus.op = 2'b10; bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.A = (i % 2 == 1) ? 12'hFFF : 12'h000;
      step();
      if (bus.out_valid !== 1'b1 || bus.C !== ((i % 2 == 1) ? 12'h555 : 12'h000))
        chk("stream_head", {19'd0, bus.out_valid, bus.C}, {19'd0, 1'b1, ((i % 2 == 1) ? 12'h555 : 12'h000)});
    end
    bus.in_valid = 1'b0;
    chk("stream_op_count", 32'(bus.op_count), 32'd110);
    step();

    // Reset with three entries queued.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.B = 12'h000; bus.op = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      bus.A = 12'(i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("preq_op_count", 32'(bus.op_count), 32'd113);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_op_count", 32'(bus.op_count), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    one(12'h001, 12'h002, 2'b00, 12'h003, 1'b0, 1'b0, "post_rst_add");
    chk("post_rst_op_count", 32'(bus.op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
